// File: rtl/fetch_queue_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : fetch_queue_if
//  Purpose  : Fetch-side push, decode-side pop and flush signals of the fetch queue.
//  Revision : 1.0
// ============================================================================
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_pc;
    logic [31:0]         in_instr;
    logic                in_pred_taken;
    logic [31:0]         in_pred_target;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_pc;
    logic [31:0]         out_instr;
    logic                out_pred_taken;
    logic [31:0]         out_pred_target;
    logic [c_CNT_W-1:0]  count;

    // Queue side
    modport slave (
        input  flush, in_valid, in_pc, in_instr, in_pred_taken, in_pred_target, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_pred_taken, out_pred_target, count
    );

    // Fetch/decode/EX side
    modport master (
        output flush, in_valid, in_pc, in_instr, in_pred_taken, in_pred_target, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_pred_taken, out_pred_target, count
    );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Fetch-to-decode decoupling FIFO with single-cycle flush.
//  Revision : 1.0
// ============================================================================
module fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  wire logic      clk,
    input  wire logic      rst,
    fetch_queue_if.slave   bus
);
    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    logic [31:0]        r_pc_mem     [DEPTH];
    logic [31:0]        r_instr_mem  [DEPTH];
    logic               r_taken_mem  [DEPTH];
    logic [31:0]        r_target_mem [DEPTH];

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;

    // in_ready is purely registered so fetch pc_en never sees decode's out_ready
    assign w_in_ready  = (r_count != c_FULL);
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid & w_in_ready & ~bus.flush;
    assign w_pop       = w_out_valid & bus.out_ready & ~bus.flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]     <= bus.in_pc;
            r_instr_mem[r_wr_ptr]  <= bus.in_instr;
            r_taken_mem[r_wr_ptr]  <= bus.in_pred_taken;
            r_target_mem[r_wr_ptr] <= bus.in_pred_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Empty queue presents a canonical NOP bundle instead of stale storage
    assign bus.in_ready        = w_in_ready;
    assign bus.out_valid       = w_out_valid;
    assign bus.out_pc          = w_out_valid ? r_pc_mem[r_rd_ptr]     : 32'h0;
    assign bus.out_instr       = w_out_valid ? r_instr_mem[r_rd_ptr]  : NOP_INSTR;
    assign bus.out_pred_taken  = w_out_valid & r_taken_mem[r_rd_ptr];
    assign bus.out_pred_target = w_out_valid ? r_target_mem[r_rd_ptr] : 32'h0;
    assign bus.count           = r_count;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && (r_count == c_FULL)));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(w_pop && (r_count == '0)));

endmodule
`default_nettype wire
